// File: rtl/alu_pkg.sv
// Shared ALU opcodes and multiply-sequencer state encoding.
// Imported by the ALU, the sequencer and the bench.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ABS_M,
    ABS_Q,
    ITER,
    NEG_LO,
    NEG_HI,
    DONE
  } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Operand/result bus between the multiply sequencer and the ALU.
// The sequencer is master (drives operands), the ALU is slave.
interface alu_mul_sequencer_if #(
  parameter int W = 8
) ();

  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [1:0]   alu_control;
  logic [W-1:0] alu_out;
  logic         alu_co;

  modport master (
    output alu_a,
    output alu_b,
    output alu_control,
    input  alu_out,
    input  alu_co
  );

  modport slave (
    input  alu_a,
    input  alu_b,
    input  alu_control,
    output alu_out,
    output alu_co
  );

endinterface

// File: rtl/alu.sv
// 4-op combinational datapath ALU: ADD, SUB, AND, OR.
// For SUB the carry out is 1 when no borrow occurs.
module alu
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  alu_mul_sequencer_if.slave bus
);

  logic [W:0] sum;

  always_comb begin
    sum         = '0;
    bus.alu_out = '0;
    bus.alu_co  = 1'b0;
    unique case (bus.alu_control)
      ALU_ADD: begin
        sum = {1'b0, bus.alu_a}
            + {1'b0, bus.alu_b};
        {bus.alu_co, bus.alu_out} = sum;
      end
      ALU_SUB: begin
        sum = {1'b0, bus.alu_a}
            + {1'b0, ~bus.alu_b}
            + {{W{1'b0}}, 1'b1};
        {bus.alu_co, bus.alu_out} = sum;
      end
      ALU_AND: bus.alu_out = bus.alu_a & bus.alu_b;
      ALU_OR:  bus.alu_out = bus.alu_a | bus.alu_b;
      default: bus.alu_out = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier controller; all W-bit add/sub work
// is pushed through the external ALU, signed via sign-magnitude.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [W-1:0]         multiplicand,
  input  logic [W-1:0]         multiplier,
  alu_mul_sequencer_if.master  alu,
  output logic                 busy,
  output logic                 done,
  output logic [2*W-1:0]       product
);

  localparam int CW = $clog2(W) + 1;

  seq_state_e    state_q, state_d;
  logic [W-1:0]  mr_q, mr_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d;
  logic          cs_q, cs_d;
  logic [2*W-1:0] product_q;

  always_comb begin
    state_d         = state_q;
    mr_d            = mr_q;
    hi_d            = hi_q;
    lo_d            = lo_q;
    cnt_d           = cnt_q;
    neg_d           = neg_q;
    cs_d            = cs_q;
    alu.alu_a       = '0;
    alu.alu_b       = '0;
    alu.alu_control = ALU_ADD;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mr_d    = multiplicand;
          lo_d    = multiplier;
          hi_d    = '0;
          cnt_d   = '0;
          neg_d   = signed_mode
                  & (multiplicand[W-1]
                  ^ multiplier[W-1]);
          state_d = signed_mode ? ABS_M : ITER;
        end
      end
      ABS_M: begin
        alu.alu_b       = mr_q;
        alu.alu_control = ALU_SUB;
        if (mr_q[W-1]) mr_d = alu.alu_out;
        state_d = ABS_Q;
      end
      ABS_Q: begin
        alu.alu_b       = lo_q;
        alu.alu_control = ALU_SUB;
        if (lo_q[W-1]) lo_d = alu.alu_out;
        state_d = ITER;
      end
      ITER: begin
        alu.alu_a = hi_q;
        alu.alu_b = lo_q[0] ? mr_q : '0;
        // carry lands in HI[W-1]; LSB of HI shifts into LO
        {hi_d, lo_d} = {alu.alu_co, alu.alu_out,
                        lo_q[W-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1))
          state_d = neg_q ? NEG_LO : DONE;
      end
      NEG_LO: begin
        alu.alu_b       = lo_q;
        alu.alu_control = ALU_SUB;
        lo_d            = alu.alu_out;
        cs_d            = alu.alu_co;
        state_d         = NEG_HI;
      end
      NEG_HI: begin
        alu.alu_a = ~hi_q;
        alu.alu_b = {{(W-1){1'b0}}, cs_q};
        hi_d      = alu.alu_out;
        state_d   = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mr_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      cs_q      <= 1'b0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      mr_q    <= mr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      cs_q    <= cs_d;
      if (state_d == DONE)
        product_q <= {hi_d, lo_d};
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed + random bench for alu_mul_sequencer wired to the ALU.
// Expected products/latencies come from plain arithmetic.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [7:0]  multiplicand = '0;
  logic [7:0]  multiplier = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_mul_sequencer_if #(.W(8)) bus ();

  alu #(.W(8)) u_alu (.bus(bus));

  alu_mul_sequencer #(.W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .alu          (bus),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(
    input logic sm, input logic [7:0] m,
    input logic [7:0] q);
    int p;
    logic signed [7:0] sa;
    logic signed [7:0] sb;
    sa = m;
    sb = q;
    if (sm) p = int'(sa) * int'(sb);
    else    p = int'(m) * int'(q);
    return p[15:0];
  endfunction

  function automatic int ref_lat(
    input logic sm, input logic [7:0] m,
    input logic [7:0] q);
    if (!sm) return 9;
    return (m[7] ^ q[7]) ? 13 : 11;
  endfunction

  logic [15:0] last_exp;

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic sm,
                        input logic [7:0] m,
                        input logic [7:0] q,
                        input int pulse_cyc,
                        input string tag);
    int n;
    int busy_cnt;
    int bad_op;
    bit seen;
    logic [15:0] exp;
    int lat;
    exp = ref_mul(sm, m, q);
    lat = ref_lat(sm, m, q);
    last_exp = exp;
    signed_mode  = sm;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    busy_cnt = 0;
    bad_op = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) busy_cnt++;
      if (bus.alu_control > 2'd1) bad_op++;
      if (pulse_cyc != 0 && n == pulse_cyc) begin
        start        = 1'b1;
        multiplicand = ~m;
        multiplier   = q + 8'd1;
        signed_mode  = ~sm;
      end else if (pulse_cyc != 0 &&
                   n == pulse_cyc + 1) begin
        start = 1'b0;
      end
      if (done) seen = 1;
    end
    chk($sformatf("%s done_seen", tag), 32'(seen), 32'd1);
    chk($sformatf("%s latency", tag), n, lat);
    chk($sformatf("%s busy_cycles", tag), busy_cnt, lat);
    chk($sformatf("%s product", tag), 32'(product), 32'(exp));
    chk($sformatf("%s alu_op_legal", tag), bad_op, 0);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk($sformatf("%s done_pulse", tag), 32'(done), 32'd0);
    chk($sformatf("%s busy_idle", tag), 32'(busy), 32'd0);
    chk($sformatf("%s product_hold", tag),
        32'(product), 32'(last_exp));
  endtask

  initial begin
    logic sm;
    logic [7:0] m;
    logic [7:0] q;

    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst product", 32'(product), 32'd0);
    chk("rst alu_a", 32'(bus.alu_a), 32'd0);
    chk("rst alu_b", 32'(bus.alu_b), 32'd0);
    chk("rst alu_control", 32'(bus.alu_control), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(1'b0, 8'd13, 8'd11, 0, "u13x11");
    chk("u13x11 const", 32'(product), 32'h008F);
    check_idle("u13x11");
    run_op(1'b0, 8'd255, 8'd255, 0, "u255x255");
    chk("u255x255 const", 32'(product), 32'hFE01);
    check_idle("u255x255");
    run_op(1'b1, 8'hFD, 8'd5, 0, "s-3x5");
    chk("s-3x5 const", 32'(product), 32'hFFF1);
    check_idle("s-3x5");
    run_op(1'b1, 8'h80, 8'h80, 0, "s-128x-128");
    chk("s-128x-128 const", 32'(product), 32'h4000);
    check_idle("s-128x-128");
    run_op(1'b1, 8'h00, 8'hF9, 0, "s0x-7");
    chk("s0x-7 const", 32'(product), 32'h0000);
    check_idle("s0x-7");

    run_op(1'b0, 8'd200, 8'd3, 3, "start_in_iter");
    signed_mode  = 1'b0;
    multiplicand = 8'd9;
    multiplier   = 8'd9;
    start        = 1'b1;
    @(negedge clk);
    chk("start_in_done busy", 32'(busy), 32'd0);
    chk("start_in_done product",
        32'(product), 32'(last_exp));
    run_op(1'b0, 8'd9, 8'd9, 0, "start_in_idle");
    check_idle("start_in_idle");

    signed_mode  = 1'b0;
    multiplicand = 8'd100;
    multiplier   = 8'd100;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst busy", 32'(busy), 32'd0);
    chk("mid_rst done", 32'(done), 32'd0);
    chk("mid_rst product", 32'(product), 32'd0);
    chk("mid_rst alu_b", 32'(bus.alu_b), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op(1'b0, 8'd7, 8'd6, 0, "u7x6");
    chk("u7x6 const", 32'(product), 32'h002A);
    check_idle("u7x6");

    for (int i = 0; i < 16; i++) begin
      sm = 1'($urandom_range(1, 0));
      m  = 8'($urandom);
      q  = 8'($urandom);
      run_op(sm, m, q, 0, $sformatf("rnd%0d", i));
      check_idle($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
Multi-cycle shift-and-add multiplier controller that sits directly upstream of the 4-op datapath ALU (ADD=0, SUB=1, AND=2, OR=3) and also consumes its result.
- It drives the ALU operands and opcode every cycle and captures the ALU sum and carry.
- It produces a 2W-bit product in signed or unsigned mode.
- This adds multiply to the datapath without a hardware multiplier; all W-bit add/subtract work goes through the ALU.

Parameters:
W, 8, operand width; must match the ALU width. Product width is 2W.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; latched at start
multiplicand  input  W  operand M; latched at start
multiplier  input  W  operand Q; latched at start
alu_a  output  W  ALU operand A
alu_b  output  W  ALU operand B
alu_control  output  2  ALU opcode; only 0 (ADD) and 1 (SUB) are ever driven
alu_out  input  W  ALU result, combinational from alu_a/alu_b/alu_control in the same cycle
alu_co  input  1  ALU carry out; for SUB, 1 = no borrow
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse in DONE
product  output  2W  result; holds until the next accepted start or reset

Behaviour:
- Reset (synchronous, active-high) takes effect on any edge with rst=1, including mid-operation:
  - state=IDLE, product=0, done=0, busy=0, internal registers=0;
  - alu_a=0, alu_b=0, alu_control=0.
- Internal registers:
  - Mr (W): latched multiplicand.
  - HI (W) and LO (W): partial product and shifted multiplier.
  - cnt: counter of width clog2(W)+1.
  - neg: result-sign flag.
  - cs: saved carry.
- IDLE, start=1:
  - Mr<=multiplicand, LO<=multiplier, HI<=0, cnt<=0.
  - neg<=signed_mode & (multiplicand[W-1]^multiplier[W-1]).
  - Next state: signed_mode ? ABS_M : ITER.
- start outside IDLE is ignored; operands are not re-latched.
- ABS_M: drive alu_a=0, alu_b=Mr, SUB. If Mr[W-1]=1 then Mr<=alu_out (magnitude; -2^(W-1) becomes 2^(W-1) unsigned, which is correct). Next state: ABS_Q.
- ABS_Q: same as ABS_M applied to LO. Next state: ITER.
- ITER: drive alu_a=HI, alu_b=LO[0] ? Mr : 0, ADD.
  - On the edge: {HI,LO} <= {alu_co, alu_out, LO[W-1:1]}, cnt<=cnt+1.
  - When cnt==W-1: next state is neg ? NEG_LO : DONE.
- NEG_LO: drive alu_a=0, alu_b=LO, SUB. LO<=alu_out, cs<=alu_co. Next state: NEG_HI.
- NEG_HI: drive alu_a=~HI, alu_b={(W-1)'b0, cs}, ADD. HI<=alu_out, giving the two's complement of {HI,LO}. Next state: DONE.
- DONE:
  - product<={HI,LO} registered on entry, so it is valid in the same cycle as done.
  - done=1 for exactly one cycle. Next state: IDLE.
- Fixed latency, counted from the edge that samples start to the first cycle with done=1:
  - unsigned: W+1 cycles;
  - signed: W+3 cycles, or W+5 when neg=1.
  - ABS cycles are always spent, even for positive operands.
- Non-active phases (IDLE, DONE) drive alu_a=0, alu_b=0, ADD.
- No product overflow is possible: the full 2W-bit result is always representable.
- start in the DONE cycle is ignored; the next request is accepted in IDLE one cycle later.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode constants ALU_ADD=2'd0, ALU_SUB=2'd1, ALU_AND=2'd2, ALU_OR=2'd3;
  - state enumeration (IDLE, ABS_M, ABS_Q, ITER, NEG_LO, NEG_HI, DONE).
- No sub-module inside the sequencer.
- The verification top instantiates the existing ALU (W=8) next to alu_mul_sequencer and wires alu_a, alu_b, alu_control, alu_out and alu_co between them.

Test Plan:
- Unsigned 13*11, W=8 -> done 9 cycles after start, product=16'h008F, busy high for 9 cycles.
- Unsigned 255*255 -> product=16'hFE01; exercises alu_co capture into HI every iteration.
- Signed -3*5 -> neg=1, done 13 cycles after start, product=16'hFFF1.
- Signed -128*-128 -> product=16'h4000. Signed 0*-7 -> product=16'h0000, which checks the cs path in NEG_LO/NEG_HI.
- Pulse start during ITER with different operands -> ignored; the original product is delivered. Then start in the DONE cycle -> ignored; start again in IDLE -> accepted.
- Assert rst during cycle 5 of ITER -> next cycle busy=0, done=0, product=0, state IDLE; a subsequent 7*6 returns 16'h002A.
